ssd_scan_controller: RTL

- Time-multiplexed scan driver for the 4-digit common-anode seven-segment display.
- Consumes the 32-bit active-low `char_seq` word produced by the SSD decoder and drives one digit at a time: anode select, segments and decimal point.
- Double-buffers `char_seq` so a new word only takes effect at a frame boundary, which prevents tearing.
- Inserts a dead-time blank at the start of every digit slot to suppress ghosting.

---
 rtl/ssd_pkg.sv | 35 +++
 rtl/ssd_slot_timer.sv | 55 +++++
 rtl/ssd_scan_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssd_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = BYTE_W * NUM_DIGITS;
  localparam int unsigned DP_BIT     = 7;
  localparam int unsigned SEG_MSB    = 6;

  localparam logic [BYTE_W-1:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_e;

  typedef struct packed {
    logic       dp;
    logic [6:0] seg;
  } seg_byte_t;

  // Extract the active-low {dp,seg} pattern of one digit from the packed word.
  function automatic seg_byte_t digit_byte(input logic [WORD_W-1:0] word,
                                           input logic [DIGIT_W-1:0] idx);
    logic [BYTE_W-1:0] raw;
    seg_byte_t         b;
    raw   = word[{idx, 3'b000} +: BYTE_W];
    b.dp  = raw[DP_BIT];
    b.seg = raw[SEG_MSB:0];
    return b;
  endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Slot and digit counters for the display scan; strobes are combinational.
module ssd_slot_timer
  import ssd_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 100000,
  parameter int unsigned DEAD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               run_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               dead_end_c_o,
  output logic               slot_end_c_o,
  output logic               frame_end_c_o
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);

  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;

  assign dead_end_c_o  = (slot_cnt_q == CNT_W'(DEAD_CYCLES - 1));
  assign slot_end_c_o  = (slot_cnt_q == CNT_W'(SLOT_CYCLES - 1));
  assign frame_end_c_o = slot_end_c_o && (digit_q == DIGIT_W'(NUM_DIGITS - 1));
  assign digit_o       = digit_q;

  // Counters hold while the scanner is idle so a restart begins at slot 0.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    digit_d    = digit_q;
    if (clear_i) begin
      slot_cnt_d = '0;
      digit_d    = '0;
    end else if (run_i) begin
      if (slot_end_c_o) begin
        slot_cnt_d = '0;
        digit_d    = digit_q + DIGIT_W'(1);
      end else begin
        slot_cnt_d = slot_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      digit_q    <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      digit_q    <= digit_d;
    end
  end

endmodule

// File: rtl/ssd_scan_controller.sv
// Tear-free, dead-time-blanked scan driver for a 4-digit common-anode display.
// Optional macro SSD_DIM_EN adds a 3-bit PWM brightness input.
module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 100000,
  parameter int unsigned DEAD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     char_seq,
  input  logic                  load,
  input  logic                  enable,
`ifdef SSD_DIM_EN
  input  logic [2:0]            brightness,
`endif
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_MSB:0]      seg,
  output logic                  dp,
  output logic                  frame_done
);

  state_e                state_q, state_d;
  logic [WORD_W-1:0]     active_q, active_d;
  logic [WORD_W-1:0]     shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_MSB:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic [DIGIT_W-1:0]    digit;
  logic                  dead_end_c, slot_end_c, frame_end_c;
  logic                  swap_c;
  logic                  anode_on_c;
  seg_byte_t             cur_c;

`ifdef SSD_DIM_EN
  logic [2:0] pwm_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_q + 3'(1);
  end

  assign anode_on_c = (pwm_cnt_q <= brightness);
`else
  assign anode_on_c = 1'b1;
`endif

  ssd_slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_slot_timer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (~enable),
    .run_i        (state_q != IDLE),
    .digit_o      (digit),
    .dead_end_c_o (dead_end_c),
    .slot_end_c_o (slot_end_c),
    .frame_end_c_o(frame_end_c)
  );

  assign cur_c = digit_byte(active_q, digit);

  // Next state, buffer swap at frame boundaries, and next output values.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    an_d         = '1;
    seg_d        = SEG_BLANK[SEG_MSB:0];
    dp_d         = SEG_BLANK[DP_BIT];
    frame_done_d = 1'b0;
    swap_c       = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = BLANK;
        swap_c  = 1'b1;
      end
      BLANK: begin
        if (dead_end_c) state_d = DRIVE;
      end
      DRIVE: begin
        if (anode_on_c) an_d = ~(NUM_DIGITS'(1) << digit);
        seg_d = cur_c.seg;
        dp_d  = cur_c.dp;
        if (slot_end_c) state_d = BLANK;
        if (frame_end_c) begin
          swap_c       = 1'b1;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disabling overrides the scan: go idle, blank now, no boundary event.
    if (!enable) begin
      state_d      = IDLE;
      swap_c       = 1'b0;
      frame_done_d = 1'b0;
      an_d         = '1;
      seg_d        = SEG_BLANK[SEG_MSB:0];
      dp_d         = SEG_BLANK[DP_BIT];
    end

    if (load) begin
      shadow_d  = char_seq;
      pending_d = 1'b1;
    end

    // A load landing on the boundary itself bypasses the shadow buffer.
    if (swap_c) begin
      if (load) begin
        active_d  = char_seq;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      active_q     <= {NUM_DIGITS{SEG_BLANK}};
      shadow_q     <= {NUM_DIGITS{SEG_BLANK}};
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK[SEG_MSB:0];
      dp_q         <= SEG_BLANK[DP_BIT];
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
